// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, FSM state encoding and ALU operation encoding for mips_multi.
package mips_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef logic [2:0] state_t;
  localparam state_t StFetch  = 3'd0;
  localparam state_t StDecode = 3'd1;
  localparam state_t StExec   = 3'd2;
  localparam state_t StMem    = 3'd3;
  localparam state_t StWb     = 3'd4;
  localparam state_t StTrap   = 3'd5;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluAnd = 3'd2,
    AluOr  = 3'd3,
    AluSlt = 3'd4
  } alu_op_e;

  function automatic logic is_supported(logic [5:0] op, logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OpRtype: begin
        case (fn)
          FnAdd, FnSub, FnAnd, FnOr, FnSlt: ok = 1'b1;
          default:                          ok = 1'b0;
        endcase
      end
      OpAddi, OpLw, OpSw, OpBeq, OpBne, OpJ: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Wrap-around arithmetic; slt compares as signed.
  function automatic logic [31:0] alu(alu_op_e op, logic [31:0] a, logic [31:0] b);
    logic [31:0] y;
    case (op)
      AluAdd:  y = a + b;
      AluSub:  y = a - b;
      AluAnd:  y = a & b;
      AluOr:   y = a | b;
      AluSlt:  y = {31'd0, $signed(a) < $signed(b)};
      default: y = 32'd0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/mips_multi_ctl.sv
// Control FSM for the multi-cycle MIPS core: sequences FETCH/DECODE/EXEC/MEM/WB/TRAP and
// produces the datapath enables.
module mips_multi_ctl
  import mips_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       mem_ready_i,
  input  logic       a_eq_b_i,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       addr_sel_o,
  output logic       ir_we_o,
  output logic       pc_inc_o,
  output logic       ab_we_o,
  output logic       res_we_o,
  output logic       addr_we_o,
  output logic       pc_br_o,
  output logic       pc_jmp_o,
  output logic       mdr_we_o,
  output logic       rf_we_o,
  output logic       rf_dst_rd_o,
  output logic       rf_src_mdr_o,
  output logic       alu_imm_o,
  output logic       retire_o,
  output logic       trap_o,
  output alu_op_e    alu_op_o
);

  state_t state_q, state_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    alu_op_o = AluAdd;
    if (opcode_i == OpRtype) begin
      case (funct_i)
        FnSub:   alu_op_o = AluSub;
        FnAnd:   alu_op_o = AluAnd;
        FnOr:    alu_op_o = AluOr;
        FnSlt:   alu_op_o = AluSlt;
        default: alu_op_o = AluAdd;
      endcase
    end
  end

  assign alu_imm_o    = (opcode_i != OpRtype);
  assign rf_dst_rd_o  = (opcode_i == OpRtype);
  assign rf_src_mdr_o = (opcode_i == OpLw);
  assign trap_o       = (state_q == StTrap);

  always_comb begin
    state_d     = state_q;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    addr_sel_o  = 1'b0;
    ir_we_o     = 1'b0;
    pc_inc_o    = 1'b0;
    ab_we_o     = 1'b0;
    res_we_o    = 1'b0;
    addr_we_o   = 1'b0;
    pc_br_o     = 1'b0;
    pc_jmp_o    = 1'b0;
    mdr_we_o    = 1'b0;
    rf_we_o     = 1'b0;
    retire_o    = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read_o = 1'b1;
        if (mem_ready_i) begin
          ir_we_o  = 1'b1;
          pc_inc_o = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        if (is_supported(opcode_i, funct_i)) begin
          ab_we_o = 1'b1;
          state_d = StExec;
        end else begin
          state_d = StTrap;
        end
      end
      StExec: begin
        case (opcode_i)
          OpRtype, OpAddi: begin
            res_we_o = 1'b1;
            state_d  = StWb;
          end
          OpLw, OpSw: begin
            addr_we_o = 1'b1;
            state_d   = StMem;
          end
          OpBeq, OpBne: begin
            pc_br_o  = (opcode_i == OpBeq) ? a_eq_b_i : !a_eq_b_i;
            retire_o = 1'b1;
            state_d  = StFetch;
          end
          OpJ: begin
            pc_jmp_o = 1'b1;
            retire_o = 1'b1;
            state_d  = StFetch;
          end
          default: state_d = StTrap;
        endcase
      end
      StMem: begin
        addr_sel_o = 1'b1;
        if (opcode_i == OpLw) begin
          mem_read_o = 1'b1;
          if (mem_ready_i) begin
            mdr_we_o = 1'b1;
            state_d  = StWb;
          end
        end else begin
          mem_write_o = 1'b1;
          if (mem_ready_i) begin
            retire_o = 1'b1;
            state_d  = StFetch;
          end
        end
      end
      StWb: begin
        rf_we_o  = 1'b1;
        retire_o = 1'b1;
        state_d  = StFetch;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
  end

endmodule

// File: rtl/mips_multi.sv
// Multi-cycle MIPS subset core: datapath and GPR file, control in mips_multi_ctl.
// Optional cycle/retire counters are built when MIPS_MULTI_PERF_EN is defined.
module mips_multi
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      mem_addr,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic [31:0]      pc_out,
  output logic             trap
`ifdef MIPS_MULTI_PERF_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt
`endif
);

  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, tgt_q, tgt_d;
  logic [31:0] res_q, res_d, addr_q, addr_d, mdr_q, mdr_d;
  logic [31:0] gpr_q [32];

  logic    ctl_read, ctl_write, addr_sel, ir_we, pc_inc, ab_we, res_we, addr_we;
  logic    pc_br, pc_jmp, mdr_we, rf_we, rf_dst_rd, rf_src_mdr, alu_imm, retire;
  alu_op_e alu_op;

  logic [4:0]  rs, rt, rd, wb_dst;
  logic [31:0] imm_sext, rf_a, rf_b, alu_b, alu_y, wb_data;

  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign rf_a     = (rs == 5'd0) ? 32'd0 : gpr_q[rs];
  assign rf_b     = (rt == 5'd0) ? 32'd0 : gpr_q[rt];
  assign alu_b    = alu_imm ? imm_sext : b_q;
  assign alu_y    = alu(alu_op, a_q, alu_b);
  assign wb_dst   = rf_dst_rd ? rd : rt;
  assign wb_data  = rf_src_mdr ? mdr_q : res_q;

  mips_multi_ctl u_ctl (
    .clk_i       (clk),
    .rst_i       (reset),
    .opcode_i    (ir_q[31:26]),
    .funct_i     (ir_q[5:0]),
    .mem_ready_i (mem_ready),
    .a_eq_b_i    (a_q == b_q),
    .mem_read_o  (ctl_read),
    .mem_write_o (ctl_write),
    .addr_sel_o  (addr_sel),
    .ir_we_o     (ir_we),
    .pc_inc_o    (pc_inc),
    .ab_we_o     (ab_we),
    .res_we_o    (res_we),
    .addr_we_o   (addr_we),
    .pc_br_o     (pc_br),
    .pc_jmp_o    (pc_jmp),
    .mdr_we_o    (mdr_we),
    .rf_we_o     (rf_we),
    .rf_dst_rd_o (rf_dst_rd),
    .rf_src_mdr_o(rf_src_mdr),
    .alu_imm_o   (alu_imm),
    .retire_o    (retire),
    .trap_o      (trap),
    .alu_op_o    (alu_op)
  );

  // Requests are gated by reset so an in-flight transfer is dropped in the same cycle.
  assign mem_read  = ctl_read & ~reset;
  assign mem_write = ctl_write & ~reset;
  assign mem_addr  = addr_sel ? addr_q : pc_q;
  assign mem_wdata = b_q;
  assign pc_out    = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (pc_inc) begin
      pc_d = pc_q + 32'd4;
    end else if (pc_br) begin
      pc_d = tgt_q;
    end else if (pc_jmp) begin
      pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
    end
    ir_d   = ir_we ? mem_rdata : ir_q;
    a_d    = ab_we ? rf_a : a_q;
    b_d    = ab_we ? rf_b : b_q;
    tgt_d  = ab_we ? pc_q + {imm_sext[29:0], 2'b00} : tgt_q;
    res_d  = res_we ? alu_y : res_q;
    addr_d = addr_we ? a_q + imm_sext : addr_q;
    mdr_d  = mdr_we ? mem_rdata : mdr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      ir_q   <= 32'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      tgt_q  <= 32'd0;
      res_q  <= 32'd0;
      addr_q <= 32'd0;
      mdr_q  <= 32'd0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      a_q    <= a_d;
      b_q    <= b_d;
      tgt_q  <= tgt_d;
      res_q  <= res_d;
      addr_q <= addr_d;
      mdr_q  <= mdr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        gpr_q[i] <= 32'd0;
      end
    end else if (rf_we && wb_dst != 5'd0) begin
      gpr_q[wb_dst] <= wb_data;
    end
  end

`ifdef MIPS_MULTI_PERF_EN
  logic [CNT_W-1:0] cyc_q, ret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (retire) begin
        ret_q <= ret_q + CNT_W'(1);
      end
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`else
  logic unused_perf;
  assign unused_perf = retire ^ (CNT_W == 0);
`endif

endmodule

// File: tb/tb_mips_multi.sv
// Directed self-checking bench for mips_multi: table-driven program run plus hand-written
// wait-state, branch-loop, trap and mid-transfer reset sequences.
module tb_mips_multi;

  logic        clk, reset;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic        mem_read, mem_write, mem_ready, trap;
`ifdef MIPS_MULTI_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  mips_multi dut (
    .clk      (clk),
    .reset    (reset),
    .mem_addr (mem_addr),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .pc_out   (pc_out),
    .trap     (trap)
`ifdef MIPS_MULTI_PERF_EN
    ,
    .cyc_cnt  (cyc_cnt),
    .ret_cnt  (ret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [64];
  assign mem_rdata = mem[mem_addr[7:2]];

  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  int          trap_req_cnt = 0;
  logic [31:0] last_wr_addr, last_wr_data;

  always @(posedge clk) begin
    if (mem_write && mem_ready) begin
      mem[mem_addr[7:2]] = mem_wdata;
      wr_cnt++;
      last_wr_addr = mem_addr;
      last_wr_data = mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) both_cnt++;
    if (trap && (mem_read || mem_write)) trap_req_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    int          r;    // 32 selects memory word 2 instead of a GPR
    logic [31:0] val;
  } vec_t;

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{4, 32'h04, 1, 32'd5};
    vecs[1]  = '{4, 32'h08, 2, 32'd7};
    vecs[2]  = '{4, 32'h0C, 3, 32'd12};
    vecs[3]  = '{4, 32'h10, 32, 32'd12};
    vecs[4]  = '{4, 32'h14, 0, 32'd0};
    vecs[5]  = '{4, 32'h18, 4, 32'hFFFF_FFFE};
    vecs[6]  = '{4, 32'h1C, 5, 32'd1};
    vecs[7]  = '{4, 32'h20, 6, 32'd5};
    vecs[8]  = '{4, 32'h24, 7, 32'd7};
    vecs[9]  = '{5, 32'h28, 8, 32'd12};
    vecs[10] = '{3, 32'h2C, 8, 32'd12};
    vecs[11] = '{3, 32'h40, 3, 32'd12};
    vecs[12] = '{3, 32'h40, 1, 32'd5};
    vecs[13] = '{3, 32'h40, 2, 32'd7};

    // Main program
    reset = 1'b1;
    mem_ready = 1'b1;
    clear_mem();
    mem[0]  = enc_i(6'h08, 0, 1, 16'd5);        // addi $1,$0,5
    mem[1]  = enc_i(6'h08, 0, 2, 16'd7);        // addi $2,$0,7
    mem[2]  = enc_r(1, 2, 3, 6'h20);            // add  $3,$1,$2
    mem[3]  = enc_i(6'h2B, 0, 3, 16'd8);        // sw   $3,8($0)
    mem[4]  = enc_i(6'h08, 0, 0, 16'd9);        // addi $0,$0,9
    mem[5]  = enc_r(1, 2, 4, 6'h22);            // sub  $4,$1,$2
    mem[6]  = enc_r(4, 1, 5, 6'h2A);            // slt  $5,$4,$1
    mem[7]  = enc_r(1, 2, 6, 6'h24);            // and  $6,$1,$2
    mem[8]  = enc_r(1, 2, 7, 6'h25);            // or   $7,$1,$2
    mem[9]  = enc_i(6'h23, 0, 8, 16'd8);        // lw   $8,8($0)
    mem[10] = enc_i(6'h05, 0, 0, 16'd5);        // bne  $0,$0,+5
    mem[11] = {6'h02, 26'h10};                  // j    0x40
    mem[16] = enc_i(6'h04, 0, 0, 16'hFFFF);     // beq  $0,$0,-1
    tick(2);
    chk("reset_pc", pc_out, 32'h0);
    chk("reset_rd", {31'd0, mem_read}, 32'd0);
    chk("reset_wr", {31'd0, mem_write}, 32'd0);
    chk("reset_trap", {31'd0, trap}, 32'd0);
    reset = 1'b0;
    #1;
    chk("first_fetch_rd", {31'd0, mem_read}, 32'd1);
    chk("first_fetch_addr", mem_addr, 32'h0);
    for (int i = 0; i < 14; i++) begin
      tick(vecs[i].cyc);
      chk($sformatf("vec%0d_pc", i), pc_out, vecs[i].pc);
      if (vecs[i].r == 32) chk($sformatf("vec%0d_mem", i), mem[2], vecs[i].val);
      else chk($sformatf("vec%0d_r%0d", i, vecs[i].r), dut.gpr_q[vecs[i].r], vecs[i].val);
    end
    chk("sw_count", wr_cnt, 32'd1);
    chk("sw_addr", last_wr_addr, 32'h8);
    chk("sw_data", last_wr_data, 32'd12);

    // lw with two wait cycles in MEM
    clear_mem();
    mem[0] = enc_i(6'h23, 0, 9, 16'd12);        // lw $9,12($0)
    mem[3] = 32'hDEAD_BEEF;
    do_reset();
    tick(3);
    mem_ready = 1'b0;
    #1;
    chk("lw_wait0_rd", {31'd0, mem_read}, 32'd1);
    chk("lw_wait0_addr", mem_addr, 32'd12);
    tick(1);
    chk("lw_wait1_rd", {31'd0, mem_read}, 32'd1);
    chk("lw_wait1_addr", mem_addr, 32'd12);
    tick(1);
    chk("lw_wait2_addr", mem_addr, 32'd12);
    chk("lw_wait2_r9", dut.gpr_q[9], 32'd0);
    mem_ready = 1'b1;
    tick(2);
    chk("lw_wait_r9", dut.gpr_q[9], 32'hDEAD_BEEF);
    chk("lw_wait_next_fetch", mem_addr, 32'h4);

    // beq loop at 0x10
    clear_mem();
    mem[0] = {6'h02, 26'h4};                    // j 0x10
    mem[4] = enc_i(6'h04, 0, 0, 16'hFFFF);      // beq $0,$0,-1
    do_reset();
    tick(3);
    chk("loop_entry_pc", pc_out, 32'h10);
    for (int k = 0; k < 2; k++) begin
      tick(1);
      chk($sformatf("loop%0d_mid_pc", k), pc_out, 32'h14);
      tick(2);
      chk($sformatf("loop%0d_pc", k), pc_out, 32'h10);
    end

    // Unsupported opcode 0x3F
    clear_mem();
    mem[0] = 32'hFC00_0000;
    do_reset();
    tick(1);
    chk("pre_trap", {31'd0, trap}, 32'd0);
    tick(1);
    chk("trap_set", {31'd0, trap}, 32'd1);
    chk("trap_no_rd", {31'd0, mem_read}, 32'd0);
    tick(5);
    chk("trap_sticky", {31'd0, trap}, 32'd1);
    chk("trap_pc_hold", pc_out, 32'h4);
    chk("trap_no_requests", trap_req_cnt, 32'd0);
`ifdef MIPS_MULTI_PERF_EN
    chk("trap_ret_cnt", ret_cnt, 32'd0);
    chk("trap_cyc_cnt", cyc_cnt, 32'd7);
`endif

    // Reset while lw is stalled in MEM
    clear_mem();
    mem[0] = enc_i(6'h23, 0, 10, 16'd12);       // lw $10,12($0)
    mem[3] = 32'h1234_5678;
    do_reset();
    tick(3);
    mem_ready = 1'b0;
    #1;
    chk("mid_mem_rd", {31'd0, mem_read}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_drop_rd", {31'd0, mem_read}, 32'd0);
    chk("rst_drop_wr", {31'd0, mem_write}, 32'd0);
    chk("rst_pc", pc_out, 32'h0);
    tick(1);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("rst_r10", dut.gpr_q[10], 32'd0);
    chk("rst_refetch_rd", {31'd0, mem_read}, 32'd1);
    chk("rst_refetch_addr", mem_addr, 32'h0);
    tick(5);
    chk("rst_lw_done", dut.gpr_q[10], 32'h1234_5678);

`ifdef MIPS_MULTI_PERF_EN
    clear_mem();
    mem[0] = enc_r(0, 0, 1, 6'h20);
    mem[1] = enc_r(0, 0, 2, 6'h20);
    do_reset();
    tick(8);
    chk("perf_ret", ret_cnt, 32'd2);
    chk("perf_cyc", cyc_cnt, 32'd8);
`endif

    chk("never_both_req", both_cnt, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
